// File: rtl/cmd_frame_rx_pkg.sv
// Shared constants, state encodings and bit-timing helper for the command-frame receiver.
// Pure declarations: no latency, no backpressure.
package cmd_frame_rx_pkg;

    localparam logic [7:0] HDR_DEF     = 8'hAA;
    localparam int         FRAME_LEN   = 16;
    localparam int         PAYLOAD_LEN = 14;
    localparam int         DATA_W      = PAYLOAD_LEN * 8;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } frm_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per UART bit, truncated.
    function automatic int bit_cyc(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/cmd_frame_rx_uart_byte_rx.sv
// 8N1 UART byte deserialiser with 2-FF synchroniser and mid-bit sampling.
// byte_valid/frm_err pulse at the stop-bit sample; no backpressure, bytes must be consumed on the strobe.
module uart_byte_rx
    import cmd_frame_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_dat,
    output logic       byte_valid,
    output logic       frm_err
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam int CW      = $clog2(BIT_CYC + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF     = CW'(BIT_CYC / 2);

    logic            rx_s1;
    logic            rx_s2;
    logic            rx_prev;
    rx_state_t       st;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_dat   <= '0;
            byte_valid <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            rx_s1      <= rx;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frm_err    <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    // Line must still be low half a bit later, otherwise it was a glitch.
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s2) begin
                            st      <= RX_DATA;
                            bit_idx <= '0;
                        end else begin
                            st <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_s2, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            st <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (rx_s2) begin
                            byte_dat   <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_frame_rx.sv
// Hunts for HDR-framed, checksummed 14-byte commands on a UART line and publishes them on data.
// wren/err strobe 1 cycle after the checksum byte; no backpressure, data holds until the next good frame.
module cmd_frame_rx
    import cmd_frame_rx_pkg::*;
#(
    parameter int         CLK_FREQ  = 50_000_000,
    parameter int         BAUD      = 115200,
    parameter logic [7:0] HDR       = HDR_DEF,
    parameter int         GAP_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              rx,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    output logic              err
);

    localparam int BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
    localparam int GAP_LIM = GAP_BYTES * 10 * BIT_CYC;
    localparam int GW      = $clog2(GAP_LIM + 2);
    localparam logic [GW-1:0] GAP_SAT      = GW'(GAP_LIM + 1);
    localparam logic [3:0]    PAYLOAD_LAST = 4'(PAYLOAD_LEN - 1);

    logic [7:0]        byte_dat;
    logic              byte_valid;
    logic              frm_err;

    frm_state_t        state;
    logic [DATA_W-1:0] shadow;
    logic [7:0]        acc;
    logic [3:0]        idx;
    logic [GW-1:0]     gap_cnt;
    logic              timed_out;

    uart_byte_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_byte_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .byte_dat   (byte_dat),
        .byte_valid (byte_valid),
        .frm_err    (frm_err)
    );

    // Saturating count reaches GAP_SAT only once the gap exceeds GAP_LIM cycles.
    assign timed_out = (gap_cnt == GAP_SAT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HUNT;
            data    <= '0;
            shadow  <= '0;
            acc     <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            wren    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wren <= 1'b0;
            err  <= 1'b0;

            if (state == HUNT || byte_valid) begin
                gap_cnt <= '0;
            end else if (!timed_out) begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            case (state)
                HUNT: begin
                    if (en && byte_valid && byte_dat == HDR) begin
                        state <= PAYLOAD;
                        idx   <= '0;
                        acc   <= '0;
                    end
                end
                PAYLOAD, CHECK: begin
                    // Priority chain guarantees a single strobe even when aborts coincide.
                    if (!en) begin
                        state <= HUNT;
                    end else if (frm_err || timed_out) begin
                        err   <= 1'b1;
                        state <= HUNT;
                    end else if (byte_valid) begin
                        if (state == PAYLOAD) begin
                            shadow <= {shadow[DATA_W-9:0], byte_dat};
                            acc    <= acc + byte_dat;
                            idx    <= idx + 4'd1;
                            if (idx == PAYLOAD_LAST) begin
                                state <= CHECK;
                            end
                        end else begin
                            if (byte_dat == acc) begin
                                data <= shadow;
                                wren <= 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                            state <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Directed frames drive the UART line; expected wren/err events are queued and a monitor pops and compares them.
module tb_cmd_frame_rx;
    import cmd_frame_rx_pkg::*;

    localparam int CLK_FREQ  = 2_400_000;
    localparam int BAUD      = 100_000;
    localparam int BIT_CYC   = 24;
    localparam int GAP_BYTES = 4;

    localparam logic [111:0] P1 = 112'h0102030405060708090A0B0C0D0E;
    localparam logic [7:0]   C1 = 8'h69;
    localparam logic [111:0] P2 = 112'h101112131415161718191A1B1C1D;
    localparam logic [7:0]   C2 = 8'h3B;
    localparam logic [111:0] P3 = 112'hAA0102030405060708090A0B0C0D;
    localparam logic [7:0]   C3 = 8'h05;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         rx = 1'b1;
    logic [111:0] data;
    logic         wren;
    logic         err;

    typedef struct {
        bit           is_err;
        logic [111:0] data;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [111:0] model_data = '0;

    always #5 clk = ~clk;

    cmd_frame_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .HDR       (8'hAA),
        .GAP_BYTES (GAP_BYTES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rx    (rx),
        .data  (data),
        .wren  (wren),
        .err   (err)
    );

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_ok(input logic [111:0] p);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = p;
        exp_q.push_back(e);
        model_data = p;
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = model_data;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
        if (!stop_bit) repeat (BIT_CYC) @(negedge clk);
    endtask

    task automatic send_range(input logic [111:0] p, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(p[(13 - i) * 8 +: 8], 1'b1);
        end
    endtask

    task automatic send_frame(input logic [111:0] p, input logic [7:0] ck);
        send_byte(8'hAA, 1'b1);
        send_range(p, 0, 13);
        send_byte(ck, 1'b1);
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (wren || err)) begin
                if (wren && err) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL strobe_overlap: wren=%0b err=%0b, required not both high", wren, err);
                end else if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: wren=%0b err=%0b, required no strobe", wren, err);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_is_err", {111'b0, err}, {111'b0, e.is_err});
                    check("strobe_data", data, e.data);
                end
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_data", data, 112'h0);
        check("reset_wren", {111'b0, wren}, 112'h0);
        check("reset_err",  {111'b0, err},  112'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        en = 1'b1;

        // Good frame
        expect_ok(P1);
        send_frame(P1, C1);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Bad checksum, then a back-to-back good frame
        expect_err();
        send_frame(P1, 8'h6A);
        expect_ok(P2);
        send_frame(P2, C2);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Header value inside the payload is plain data
        expect_ok(P3);
        send_frame(P3, C3);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Inter-byte timeout, then a good frame
        expect_err();
        send_byte(8'hAA, 1'b1);
        send_range(P1, 0, 4);
        repeat (5 * 10 * BIT_CYC) @(negedge clk);
        expect_ok(P1);
        send_frame(P1, C1);
        repeat (2 * BIT_CYC) @(negedge clk);

        // en gating: whole frame ignored, then en raised mid-frame
        en = 1'b0;
        send_frame(P2, C2);
        send_byte(8'hAA, 1'b1);
        send_range(P2, 0, 2);
        en = 1'b1;
        send_range(P2, 3, 13);
        send_byte(C2, 1'b1);
        repeat (2 * BIT_CYC) @(negedge clk);
        expect_ok(P2);
        send_frame(P2, C2);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Framing error on the 7th payload byte, then resync
        expect_err();
        send_byte(8'hAA, 1'b1);
        send_range(P3, 0, 5);
        send_byte(P3[(13 - 6) * 8 +: 8], 1'b0);
        expect_ok(P3);
        send_frame(P3, C3);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Short low glitch between payload bytes must not become a byte
        expect_ok(P1);
        send_byte(8'hAA, 1'b1);
        send_range(P1, 0, 2);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (10 * BIT_CYC) @(negedge clk);
        send_range(P1, 3, 13);
        send_byte(C1, 1'b1);
        repeat (2 * BIT_CYC) @(negedge clk);

        // Reset during the 10th payload byte
        send_byte(8'hAA, 1'b1);
        send_range(P2, 0, 8);
        rx = 1'b0;
        repeat (3 * BIT_CYC) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_data", data, 112'h0);
        check("midrst_wren", {111'b0, wren}, 112'h0);
        check("midrst_err",  {111'b0, err},  112'h0);
        rx = 1'b1;
        model_data = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CYC) @(negedge clk);
        check("postrst_data", data, 112'h0);
        expect_ok(P1);
        send_frame(P1, C1);
        repeat (4 * BIT_CYC) @(negedge clk);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: %0d outstanding, required 0", exp_q.size());
        end
        check("final_data", data, P1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
